// File: rtl/thread_scheduler_pkg.sv
// Shared configuration and types for the barrel-thread scheduler.
// Defaults match the 4-context register file with a 3-cycle issue-to-writeback path.
package thread_scheduler_pkg;

    localparam int TS_NUM_THREADS = 4;
    localparam int TS_WB_LATENCY  = 3;
    localparam int TS_ID_W        = $clog2(TS_NUM_THREADS);

    typedef logic [TS_ID_W-1:0] thread_id_t;

    typedef struct packed {
        logic       valid;
        thread_id_t id;
    } thread_slot_t;

    // Rotating search index: the candidate that lies off places after base.
    function automatic int unsigned wrap_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/thread_rr_arbiter.sv
// Combinational rotate-priority picker: first eligible thread after ptr, wrapping.
// ptr itself is searched last, so the last-issued thread only wins when it is alone.
module thread_rr_arbiter
    import thread_scheduler_pkg::*;
#(
    parameter int NUM_THREADS = TS_NUM_THREADS
) (
    input  logic [NUM_THREADS-1:0]         eligible,
    input  logic [$clog2(NUM_THREADS)-1:0] ptr,
    output logic                           grant_valid,
    output logic [$clog2(NUM_THREADS)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_THREADS);

    logic [ID_W-1:0] cand_s;

    // Walk from the farthest candidate to the nearest so the nearest hit overwrites
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand_s      = '0;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            cand_s      = ID_W'(wrap_idx(32'(ptr), k, NUM_THREADS));
            grant_valid = grant_valid | eligible[cand_s];
            grant_id    = eligible[cand_s] ? cand_s : grant_id;
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin barrel-thread scheduler: issues one non-busy active thread per cycle
// and carries its ID down a writeback-aligned delay line for the register file.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int                      NUM_THREADS  = TS_NUM_THREADS,
    parameter int                      WB_LATENCY   = TS_WB_LATENCY,
    parameter logic [NUM_THREADS-1:0]  RESET_ACTIVE = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_THREADS-1:0]         thread_start,
    input  logic [NUM_THREADS-1:0]         thread_stop,
    input  logic [NUM_THREADS-1:0]         thread_stall,
    input  logic                           issue_ready,
    output logic                           issue_valid,
    output logic [$clog2(NUM_THREADS)-1:0] thread_rs_id,
    output logic                           rs_en,
    output logic [$clog2(NUM_THREADS)-1:0] thread_rd_id,
    output logic                           rd_valid,
    output logic [NUM_THREADS-1:0]         active_mask
);

    localparam int ID_W = $clog2(NUM_THREADS);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } slot_t;

    logic [NUM_THREADS-1:0] active_r;
    logic [NUM_THREADS-1:0] active_next_s;
    logic [NUM_THREADS-1:0] busy_s;
    logic [NUM_THREADS-1:0] eligible_s;
    logic [ID_W-1:0]        ptr_r;
    logic                   grant_valid_s;
    logic [ID_W-1:0]        grant_id_s;
    slot_t                  issue_r;
    slot_t                  line_r [1:WB_LATENCY];

    // Stop dominates start; starting an already-active thread is a no-op
    always_comb begin
        active_next_s = (active_r | thread_start) & ~thread_stop;
    end

    // Busy excludes the final stage: that entry writes back in the same cycle a
    // newly selected instruction would be presented, which already follows the read.
    always_comb begin
        busy_s = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            busy_s[t] = issue_r.valid && (issue_r.id == ID_W'(t));
            for (int s = 1; s < WB_LATENCY; s++) begin
                busy_s[t] = busy_s[t] | (line_r[s].valid && (line_r[s].id == ID_W'(t)));
            end
        end
    end

    // Candidates for this cycle's selection
    always_comb begin
        eligible_s = active_r & ~thread_stall & ~busy_s;
    end

    thread_rr_arbiter #(
        .NUM_THREADS (NUM_THREADS)
    ) u_arbiter (
        .eligible    (eligible_s),
        .ptr         (ptr_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Active mask keeps tracking start/stop pulses even during a global stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_r <= RESET_ACTIVE;
        end else begin
            active_r <= active_next_s;
        end
    end

    // Issue register, pointer and delay line advance together, only when the pipeline does
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_r <= '0;
            ptr_r   <= ID_W'(NUM_THREADS - 1);
            for (int s = 1; s <= WB_LATENCY; s++) begin
                line_r[s] <= '0;
            end
        end else if (issue_ready) begin
            issue_r   <= '{valid: grant_valid_s, id: grant_id_s};
            ptr_r     <= grant_valid_s ? grant_id_s : ptr_r;
            line_r[1] <= issue_r;
            for (int s = 2; s <= WB_LATENCY; s++) begin
                line_r[s] <= line_r[s-1];
            end
        end
    end

    assign issue_valid  = issue_r.valid;
    assign thread_rs_id = issue_r.id;
    assign rs_en        = issue_r.valid & issue_ready;
    assign thread_rd_id = line_r[WB_LATENCY].id;
    assign rd_valid     = line_r[WB_LATENCY].valid;
    assign active_mask  = active_r;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed table-driven bench for thread_scheduler with default parameters
// (4 threads, 3-cycle writeback); cycle n is the period after the nth edge following reset release.
module tb_thread_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] thread_start;
    logic [3:0] thread_stop;
    logic [3:0] thread_stall;
    logic       issue_ready;
    logic       issue_valid;
    logic [1:0] thread_rs_id;
    logic       rs_en;
    logic [1:0] thread_rd_id;
    logic       rd_valid;
    logic [3:0] active_mask;

    thread_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .thread_start (thread_start),
        .thread_stop  (thread_stop),
        .thread_stall (thread_stall),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .thread_rs_id (thread_rs_id),
        .rs_en        (rs_en),
        .thread_rd_id (thread_rd_id),
        .rd_valid     (rd_valid),
        .active_mask  (active_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] start;
        logic [3:0] stop;
        logic [3:0] stall;
        logic       ready;
        logic       ev;
        logic [1:0] eid;
        logic       erv;
        logic [1:0] erid;
        logic [3:0] emask;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic v(input logic [3:0] st, input logic [3:0] sp, input logic [3:0] sl, input logic rdy,
                     input logic ev, input logic [1:0] eid, input logic erv, input logic [1:0] erid,
                     input logic [3:0] em);
        vec_t e;
        e.start = st; e.stop = sp; e.stall = sl; e.ready = rdy;
        e.ev = ev; e.eid = eid; e.erv = erv; e.erid = erid; e.emask = em;
        vecs.push_back(e);
    endtask

    initial begin
        rst          = 1'b0;
        thread_start = 4'h0;
        thread_stop  = 4'h0;
        thread_stall = 4'h0;
        issue_ready  = 1'b1;

        // thread 0 alone: issues 1,5,9; writebacks 4,8
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'h1); // 1
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h1); // 2
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h1); // 3
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'h1); // 4
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'h1); // 5
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h1); // 6
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'h1); // 7
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'h1); // 8
        // start threads 1..3, then full round robin
        v(4'hE, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'h1); // 9
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'hF); // 10
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 4'hF); // 11
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 4'hF); // 12
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 4'hF); // 13
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'hF); // 14
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 4'hF); // 15
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'hF); // 16
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hF); // 17
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'hF); // 18
        // thread 2 stalled in cycles 19..23
        v(4'h0, 4'h0, 4'h4, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 4'hF); // 19
        v(4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'hF); // 20
        v(4'h0, 4'h0, 4'h4, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hF); // 21
        v(4'h0, 4'h0, 4'h4, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'hF); // 22
        v(4'h0, 4'h0, 4'h4, 1'b1, 1'b1, 2'd1, 1'b0, 2'd0, 4'hF); // 23
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'hF); // 24
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 4'hF); // 25
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 4'hF); // 26
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'hF); // 27
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 4'hF); // 28
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'hF); // 29
        // global stall in cycles 30..31
        v(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 4'hF); // 30
        v(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 4'hF); // 31
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hF); // 32
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'hF); // 33
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2, 4'hF); // 34
        // stop thread 1 one cycle after its issue; its writeback still lands at 37
        v(4'h0, 4'h2, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'hF); // 35
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hD); // 36
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 2'd1, 4'hD); // 37
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'hD); // 38
        v(4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'hD); // 39
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hD); // 40
        v(4'h1, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'hD); // 41
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'hD); // 42
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'hD); // 43
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 2'd0, 4'hD); // 44
        v(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'hD); // 45

        repeat (2) @(posedge clk);
        #1;
        chk("reset_issue_valid", 0, 32'(issue_valid), 32'd0);
        chk("reset_rs_en", 0, 32'(rs_en), 32'd0);
        chk("reset_rd_valid", 0, 32'(rd_valid), 32'd0);
        chk("reset_rs_id", 0, 32'(thread_rs_id), 32'd0);
        chk("reset_rd_id", 0, 32'(thread_rd_id), 32'd0);
        chk("reset_mask", 0, 32'(active_mask), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            thread_start = vecs[i].start;
            thread_stop  = vecs[i].stop;
            thread_stall = vecs[i].stall;
            issue_ready  = vecs[i].ready;
            @(negedge clk);
            chk("issue_valid", i + 1, 32'(issue_valid), 32'(vecs[i].ev));
            chk("rs_en", i + 1, 32'(rs_en), 32'(vecs[i].ev & vecs[i].ready));
            chk("rd_valid", i + 1, 32'(rd_valid), 32'(vecs[i].erv));
            chk("active_mask", i + 1, 32'(active_mask), 32'(vecs[i].emask));
            if (vecs[i].ev) begin
                chk("thread_rs_id", i + 1, 32'(thread_rs_id), 32'(vecs[i].eid));
            end
            if (vecs[i].erv) begin
                chk("thread_rd_id", i + 1, 32'(thread_rd_id), 32'(vecs[i].erid));
            end
        end

        // asynchronous reset mid-stream with entries in flight
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_issue_valid", 0, 32'(issue_valid), 32'd0);
        chk("async_rs_en", 0, 32'(rs_en), 32'd0);
        chk("async_rd_valid", 0, 32'(rd_valid), 32'd0);
        chk("async_rs_id", 0, 32'(thread_rs_id), 32'd0);
        chk("async_rd_id", 0, 32'(thread_rd_id), 32'd0);
        chk("async_mask", 0, 32'(active_mask), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_issue_valid", n, 32'(issue_valid), ((n == 1) || (n == 5)) ? 32'd1 : 32'd0);
            chk("post_rst_rd_valid", n, 32'(rd_valid), (n == 4) ? 32'd1 : 32'd0);
            if (n == 4) begin
                chk("post_rst_rd_id", n, 32'(thread_rd_id), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
